// File: rtl/cla_pkg.sv
// Shared types and constants for the shared-CLA arbiter: FSM states, requester
// IDs and the settle-counter width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One spare bit so SETTLE_CYCLES-1 always fits, including SETTLE_CYCLES=1.
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles) + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. Purely combinational; the last-grant
// history register is owned by the parent.
module rr_arb2
  import cla_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // On a tie, the requester that did not win last time gets the grant
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = REQ0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = REQ1;
    end else begin
      grant_id = REQ0;
    end
  end

endmodule

// File: rtl/cla_adder_arbiter.sv
// Time-shares one external combinational CLA adder between two requesters:
// round-robin accept, registered operands, fixed settle window, tagged response.
module cla_adder_arbiter
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] count_r;
  logic             last_grant_r;
  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic             capture_s;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  assign req0_ready = accept_s && (grant_id_s == REQ0);
  assign req1_ready = accept_s && (grant_id_s == REQ1);
  assign resp_valid = (state_r == RESP);
  assign busy       = (state_r != IDLE);

  // Next-state decode plus the accept and capture strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          accept_s     = 1'b1;
          state_next_s = SETTLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (count_r == {CNT_W{1'b0}}) begin
          capture_s    = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = SETTLE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, settle counter, result capture and grant history
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a        <= {WIDTH{1'b0}};
      add_b        <= {WIDTH{1'b0}};
      add_cin      <= 1'b0;
      resp_id      <= 1'b0;
      resp_sum     <= {WIDTH{1'b0}};
      resp_cout    <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      last_grant_r <= REQ1;
    end else begin
      if (accept_s) begin
        if (grant_id_s == REQ1) begin
          add_a   <= req1_a;
          add_b   <= req1_b;
          add_cin <= req1_cin;
        end else begin
          add_a   <= req0_a;
          add_b   <= req0_b;
          add_cin <= req0_cin;
        end
        resp_id      <= grant_id_s;
        last_grant_r <= grant_id_s;
        count_r      <= CNT_W'(SETTLE_CYCLES - 1);
      end
      if ((state_r == SETTLE) && !capture_s) begin
        count_r <= count_r - CNT_W'(1);
      end
      // add_* are untouched here, so they keep the last operands after completion
      if (capture_s) begin
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Self-checking bench for cla_adder_arbiter: vector table through a scoreboard,
// plus hand sequences for backpressure, fairness, settle window and mid-op reset.
module tb_cla_adder_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with SETTLE_CYCLES=1 ----------------
  logic       rst;
  logic       req0_valid, req0_ready, req0_cin;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_cin;
  logic [7:0] req1_a, req1_b;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       resp_valid, resp_ready, resp_id, resp_cout, busy;
  logic [7:0] resp_sum;
  logic [8:0] sum9;

  assign sum9 = 9'(add_a) + 9'(add_b) + 9'(add_cin);
  assign add_sum  = sum9[7:0];
  assign add_cout = sum9[8];

  cla_adder_arbiter #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy)
  );

  // ---------------- DUT with SETTLE_CYCLES=3, slow adder ----------------
  logic       rst3;
  logic       s3_req0_valid, s3_req0_ready, s3_req0_cin;
  logic [7:0] s3_req0_a, s3_req0_b;
  logic       s3_req1_valid, s3_req1_ready, s3_req1_cin;
  logic [7:0] s3_req1_a, s3_req1_b;
  logic [7:0] s3_add_a, s3_add_b, s3_add_sum;
  logic       s3_add_cin, s3_add_cout;
  logic       s3_resp_valid, s3_resp_ready, s3_resp_id, s3_resp_cout, s3_busy;
  logic [7:0] s3_resp_sum;
  logic [8:0] dly1 = 9'd0;
  logic [8:0] dly2 = 9'd0;

  // Adder whose output lags its inputs by two clocks
  always @(posedge clk) begin
    dly1 <= 9'(s3_add_a) + 9'(s3_add_b) + 9'(s3_add_cin);
    dly2 <= dly1;
  end
  assign s3_add_sum  = dly2[7:0];
  assign s3_add_cout = dly2[8];

  cla_adder_arbiter #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready), .req0_a(s3_req0_a), .req0_b(s3_req0_b), .req0_cin(s3_req0_cin),
    .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready), .req1_a(s3_req1_a), .req1_b(s3_req1_b), .req1_cin(s3_req1_cin),
    .add_a(s3_add_a), .add_b(s3_add_b), .add_cin(s3_add_cin), .add_sum(s3_add_sum), .add_cout(s3_add_cout),
    .resp_valid(s3_resp_valid), .resp_ready(s3_resp_ready), .resp_id(s3_resp_id),
    .resp_sum(s3_resp_sum), .resp_cout(s3_resp_cout), .busy(s3_busy)
  );

  // ---------------- checking infrastructure ----------------
  typedef struct packed {
    logic       id;
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   hs_cyc = 0;
  int   both_ready_cnt = 0;
  int   busy_ready_cnt = 0;
  logic rv_prev = 1'b0;
  exp_t exp0, exp1, sb_e;
  exp_t sb[$];
  logic id_log[$];
  int   hs_log[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on request handshake, pop and compare on response handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready && req1_ready) both_ready_cnt++;
      if (busy && (req0_ready || req1_ready)) busy_ready_cnt++;
      if (req0_ready) begin sb.push_back(exp0); hs_cyc = cyc; hs_log.push_back(cyc); end
      if (req1_ready) begin sb.push_back(exp1); hs_cyc = cyc; hs_log.push_back(cyc); end
      if (resp_valid && !rv_prev) check("latency", 32'(cyc - hs_cyc), 32'd2);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          sb_e = sb.pop_front();
          check("resp_id",   32'(resp_id),   32'(sb_e.id));
          check("resp_sum",  32'(resp_sum),  32'(sb_e.sum));
          check("resp_cout", 32'(resp_cout), 32'(sb_e.cout));
          id_log.push_back(resp_id);
        end
      end
    end
    rv_prev = resp_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_hs(input logic id, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin ok = 1'b1; break; end
    end
  endtask

  bit ok;
  int lat;

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{1'b0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst = 1'b1; rst3 = 1'b1;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;
    resp_ready = 1'b1;
    s3_req0_valid = 1'b0; s3_req0_a = 8'h00; s3_req0_b = 8'h00; s3_req0_cin = 1'b0;
    s3_req1_valid = 1'b0; s3_req1_a = 8'h00; s3_req1_b = 8'h00; s3_req1_cin = 1'b0;
    s3_resp_ready = 1'b1;
    exp0 = '0; exp1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_add_a",      32'(add_a),      32'd0);
    check("rst_add_b",      32'(add_b),      32'd0);
    check("rst_add_cin",    32'(add_cin),    32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id",    32'(resp_id),    32'd0);
    check("rst_resp_sum",   32'(resp_sum),   32'd0);
    check("rst_resp_cout",  32'(resp_cout),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_ready0",     32'(req0_ready), 32'd0);
    check("rst_ready1",     32'(req1_ready), 32'd0);

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vecs[i].id) begin
        req1_a = vecs[i].a; req1_b = vecs[i].b; req1_cin = vecs[i].cin;
        exp1 = '{1'b1, vecs[i].sum, vecs[i].cout}; req1_valid = 1'b1;
      end else begin
        req0_a = vecs[i].a; req0_b = vecs[i].b; req0_cin = vecs[i].cin;
        exp0 = '{1'b0, vecs[i].sum, vecs[i].cout}; req0_valid = 1'b1;
      end
      wait_hs(vecs[i].id, ok);
      check("vec_handshake", 32'(ok), 32'd1);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_resp(ok);
      check("vec_resp", 32'(ok), 32'd1);
      @(negedge clk);
      check("vec_idle_busy", 32'(busy),  32'd0);
      check("vec_add_a_hold", 32'(add_a), 32'(vecs[i].a));
      check("vec_add_b_hold", 32'(add_b), 32'(vecs[i].b));
    end

    // Backpressure: response held, no new accept while waiting
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req0_a = 8'h11; req0_b = 8'h22; req0_cin = 1'b0; exp0 = '{1'b0, 8'h33, 1'b0};
    req0_valid = 1'b1;
    wait_hs(1'b0, ok);
    check("bp_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_a = 8'h01; req1_b = 8'h02; req1_cin = 1'b0; exp1 = '{1'b1, 8'h03, 1'b0};
    req1_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    check("bp_resp_valid", 32'(ok), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(resp_valid), 32'd1);
      check("bp_sum_held",   32'(resp_sum),   32'h33);
      check("bp_id_held",    32'(resp_id),    32'd0);
      check("bp_busy",       32'(busy),       32'd1);
      check("bp_no_ready1",  32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1 resp_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", 32'(busy), 32'd0);

    // Fairness after reset: first tie goes to req0, then alternate
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); id_log.delete(); hs_log.delete();
    req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1'b0; exp0 = '{1'b0, 8'h4B, 1'b0};
    req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 1'b1; exp1 = '{1'b1, 8'h01, 1'b1};
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (id_log.size() >= 4) break;
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check("fair_count", 32'(id_log.size() >= 4), 32'd1);
    for (int j = 0; j < 4; j++) begin
      if (j < id_log.size()) check($sformatf("fair_grant%0d", j), 32'(id_log[j]), 32'(j % 2));
    end
    if (hs_log.size() >= 2) check("fair_interval", 32'(hs_log[1] - hs_log[0]), 32'd3);
    else check("fair_interval_cnt", 32'(hs_log.size()), 32'd2);

    // Settle window with slow adder: resp at T+4 with the settled sum
    @(posedge clk); #1;
    s3_req0_a = 8'h3C; s3_req0_b = 8'h0F; s3_req0_cin = 1'b0; s3_req0_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s3_req0_ready) begin ok = 1'b1; break; end
    end
    check("s3_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1 s3_req0_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s3_resp_valid) begin lat = k; break; end
    end
    check("s3_latency", 32'(lat),          32'd4);
    check("s3_sum",     32'(s3_resp_sum),  32'h4B);
    check("s3_cout",    32'(s3_resp_cout), 32'd0);
    check("s3_id",      32'(s3_resp_id),   32'd0);
    @(negedge clk);
    check("s3_idle", 32'(s3_busy), 32'd0);

    // Reset during SETTLE (asserted in cycle T+2) abandons the operation
    @(posedge clk); #1;
    s3_req0_a = 8'hAA; s3_req0_b = 8'h11; s3_req0_cin = 1'b1; s3_req0_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s3_req0_ready) begin ok = 1'b1; break; end
    end
    check("s3r_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1 s3_req0_valid = 1'b0;
    @(posedge clk); #1 rst3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s3r_no_valid", 32'(s3_resp_valid), 32'd0);
    end
    check("s3r_add_a",  32'(s3_add_a),    32'd0);
    check("s3r_add_cin", 32'(s3_add_cin), 32'd0);
    check("s3r_sum",    32'(s3_resp_sum), 32'd0);
    check("s3r_busy",   32'(s3_busy),     32'd0);
    @(posedge clk); #1 s3_req0_valid = 1'b1; s3_req1_valid = 1'b1;
    @(negedge clk);
    check("s3r_tie_ready0", 32'(s3_req0_ready), 32'd1);
    check("s3r_tie_ready1", 32'(s3_req1_ready), 32'd0);
    @(posedge clk); #1 s3_req0_valid = 1'b0; s3_req1_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!s3_busy) break;
    end

    check("never_both_ready", 32'(both_ready_cnt), 32'd0);
    check("no_ready_when_busy", 32'(busy_ready_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
